// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: AER field widths,
// the packed address-event record and the drop counter width.
package snn_pkg;

  localparam int AER_ADDR_W = 2;
  localparam int AER_TS_W   = 8;
  localparam int DROP_CNT_W = 8;

  typedef struct packed {
    logic [AER_TS_W-1:0]   ev_ts;
    logic [AER_ADDR_W-1:0] addr;
  } aer_event_t;

endpackage

// File: rtl/spike_aer_encoder_if.sv
// Valid/ready address-event output bus: the encoder drives it as master,
// the downstream consumer sits on the slave side.
interface spike_aer_encoder_if
  import snn_pkg::*;
#(
  parameter int ADDR_W = AER_ADDR_W,
  parameter int TS_W   = AER_TS_W
);

  logic              ev_valid;
  logic              ev_ready;
  logic [ADDR_W-1:0] ev_addr;
  logic [TS_W-1:0]   ev_time;

  modport master (output ev_valid, ev_addr, ev_time, input ev_ready);
  modport slave  (input ev_valid, ev_addr, ev_time, output ev_ready);

endinterface

// File: rtl/aer_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rdata the cycle
// after it is written; rdata reads zero while the FIFO is empty.
module aer_fifo #(
  parameter int  WIDTH = 10,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  // Full is judged on the registered level, so a same-cycle pop never
  // makes room for a push.
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = level_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Collects per-neuron spikes into pending bits, arbitrates them round-robin
// into an event FIFO stamped with a free-running timestamp. Optional drop
// counter is built when SPIKE_AER_DROP_COUNT_EN is defined.
module spike_aer_encoder
  import snn_pkg::*;
#(
  parameter int  N_NEURONS  = 4,
  parameter int  FIFO_DEPTH = 4,
  parameter int  TS_WIDTH   = AER_TS_W,
  localparam int AW         = $clog2(N_NEURONS),
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_NEURONS-1:0]  spike_in,
  spike_aer_encoder_if.master   ev,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic [LW-1:0]         fifo_level
);

  localparam int EW = TS_WIDTH + AW;

  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [AW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;

  logic [N_NEURONS-1:0] grant;
  logic [AW-1:0]        gnt_idx;
  logic                 gnt_vld;

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [EW-1:0]        fifo_rdata;

  // Round-robin search starting at rr_ptr; gated entirely by FIFO full.
  always_comb begin
    int      idx;
    logic [AW-1:0] ai;
    grant   = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    ai      = '0;
    if (!fifo_full) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        idx = (int'(rr_ptr_q) + k) % N_NEURONS;
        ai  = AW'(idx);
        if (!gnt_vld && pending_q[ai]) begin
          gnt_vld   = 1'b1;
          gnt_idx   = ai;
          grant[ai] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == AW'(N_NEURONS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // A spike arriving on a granted neuron re-pends it instead of dropping.
  assign pending_d = (pending_q & ~grant) | spike_in;
  assign ts_d      = ts_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
      ts_q      <= '0;
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      ts_q      <= ts_d;
    end
  end

  assign fifo_pop = !fifo_empty && ev.ev_ready;

  aer_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (gnt_vld),
    .wdata ({ts_q, gnt_idx}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign ev.ev_valid = !fifo_empty;
  assign ev.ev_time  = fifo_rdata[AW +: TS_WIDTH];
  assign ev.ev_addr  = fifo_rdata[AW-1:0];

`ifdef SPIKE_AER_DROP_COUNT_EN
  localparam int DW = $clog2(N_NEURONS + 1);
  localparam int SW = DROP_CNT_W + DW;

  logic [N_NEURONS-1:0]  drop_vec;
  logic [DW-1:0]         drop_num;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  function automatic logic [DROP_CNT_W-1:0] sat_add(
    input logic [DROP_CNT_W-1:0] a,
    input logic [DW-1:0]         b
  );
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (|s[SW-1:DROP_CNT_W]) ? {DROP_CNT_W{1'b1}} : s[DROP_CNT_W-1:0];
  endfunction

  assign drop_vec = spike_in & pending_q & ~grant;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      drop_num = drop_num + DW'(drop_vec[i]);
    end
    drop_d = sat_add(drop_q, drop_num);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: a per-cycle vector table plus
// hand-written latency and stall-stability sequences.
module tb_spike_aer_encoder;
  import snn_pkg::*;

`ifdef SPIKE_AER_DROP_COUNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] spike_in = 4'b0000;
  logic [7:0] drop_count;
  logic [2:0] fifo_level;

  spike_aer_encoder_if #(.ADDR_W(2), .TS_W(8)) ev_if ();

  spike_aer_encoder #(
    .N_NEURONS  (4),
    .FIFO_DEPTH (4),
    .TS_WIDTH   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .ev         (ev_if),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] spike;
    logic       ready;
    logic       v;
    logic [1:0] a;
    logic [7:0] t;
    logic [2:0] lvl;
    logic [7:0] drop;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int rst, int spike, int ready, int v, int a,
                              int t, int lvl, int drop);
    vec_t e;
    e.rst   = 1'(rst);
    e.spike = 4'(spike);
    e.ready = 1'(ready);
    e.v     = 1'(v);
    e.a     = 2'(a);
    e.t     = 8'(t);
    e.lvl   = 3'(lvl);
    e.drop  = 8'(drop);
    tbl.push_back(e);
  endfunction

  function automatic void add_rst(int n);
    for (int i = 0; i < n; i++) add(1, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void add_idle(int n, int ready);
    for (int i = 0; i < n; i++) add(0, 0, ready, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    spike_in       = 4'b0000;
    ev_if.ev_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;

    // Single spike at ts=10, consumer always ready.
    add_rst(2);
    add_idle(10, 1);
    add(0, 4'b0100, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 2, 11, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    // Burst of all four neurons from rr_ptr=0.
    add_rst(1);
    add(0, 4'b1111, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1, 1, 0);
    add(0, 0, 1, 1, 1, 2, 1, 0);
    add(0, 0, 1, 1, 2, 3, 1, 0);
    add(0, 0, 1, 1, 3, 4, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    // Backpressure: fill to 4, neuron 0 re-spikes and waits, then drain.
    add_rst(1);
    add(0, 4'b1111, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0001, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 2, 0);
    add(0, 0, 0, 1, 0, 1, 3, 0);
    add(0, 0, 0, 1, 0, 1, 4, 0);
    add(0, 0, 0, 1, 0, 1, 4, 0);
    add(0, 0, 1, 1, 0, 1, 4, 0);
    add(0, 0, 1, 1, 1, 2, 3, 0);
    add(0, 0, 1, 1, 2, 3, 3, 0);
    add(0, 0, 1, 1, 3, 4, 2, 0);
    add(0, 0, 1, 1, 0, 8, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    // Drops: FIFO full, neuron 1 spikes on three consecutive cycles.
    add_rst(1);
    add(0, 4'b1111, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 2, 0);
    add(0, 0, 0, 1, 0, 1, 3, 0);
    add(0, 4'b0010, 0, 1, 0, 1, 4, 0);
    add(0, 4'b0010, 0, 1, 0, 1, 4, 0);
    add(0, 4'b0010, 0, 1, 0, 1, 4, 1 * DROP_EN);
    add(0, 0, 0, 1, 0, 1, 4, 2 * DROP_EN);
    add(0, 0, 0, 1, 0, 1, 4, 2 * DROP_EN);

    // Timestamp wrap: pushes at ts=255 and ts=0.
    add_rst(1);
    add_idle(254, 1);
    add(0, 4'b0010, 1, 0, 0, 0, 0, 0);
    add(0, 4'b1000, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 255, 1, 0);
    add(0, 0, 1, 1, 3, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    // Reset with three events queued and neuron 3 still pending.
    add_rst(1);
    add(0, 4'b1111, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 2, 0);
    add_rst(2);
    add(0, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      reset          = tbl[i].rst;
      spike_in       = tbl[i].spike;
      ev_if.ev_ready = tbl[i].ready;
      #1;
      chk("ev_valid",   i, 32'(ev_if.ev_valid), 32'(tbl[i].v));
      chk("ev_addr",    i, 32'(ev_if.ev_addr),  32'(tbl[i].a));
      chk("ev_time",    i, 32'(ev_if.ev_time),  32'(tbl[i].t));
      chk("fifo_level", i, 32'(fifo_level),     32'(tbl[i].lvl));
      chk("drop_count", i, 32'(drop_count),     32'(tbl[i].drop));
      step();
    end

    // Latency: spike in the first cycle after reset shows up two edges later.
    do_reset();
    ev_if.ev_ready = 1'b1;
    spike_in       = 4'b1000;
    n = 0;
    while (n < 10 && ev_if.ev_valid !== 1'b1) begin
      step();
      spike_in = 4'b0000;
      n++;
    end
    chk("latency_cycles", 0, 32'(n), 32'd2);
    chk("latency_addr",   0, 32'(ev_if.ev_addr), 32'd3);
    chk("latency_time",   0, 32'(ev_if.ev_time), 32'd1);

    // Stall: head must hold while ready is low, then advance once ready rises.
    do_reset();
    spike_in = 4'b0011;
    step();
    spike_in = 4'b0000;
    step();
    d0 = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_valid", c, 32'(ev_if.ev_valid), 32'd1);
      chk("stall_addr",  c, 32'(ev_if.ev_addr),  32'd0);
      chk("stall_time",  c, 32'(ev_if.ev_time),  32'd1);
      d0 = c;
    end
    chk("stall_level", d0, 32'(fifo_level), 32'd2);
    ev_if.ev_ready = 1'b1;
    step();
    chk("after_stall_addr",  0, 32'(ev_if.ev_addr),  32'd1);
    chk("after_stall_time",  0, 32'(ev_if.ev_time),  32'd2);
    chk("after_stall_level", 0, 32'(fifo_level),     32'd1);
    step();
    chk("drained_valid", 0, 32'(ev_if.ev_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
